alu_op_sequencer: RTL and testbench

Initiator side of the 4-bit ALU interface, which is the select/operand in, result out interface. It accepts one operation request on a valid/ready handshake and drives the ALU select lines (S1,S0) and operands A,B. It then waits a programmable settle time, samples the ALU result bus and returns a packed response on a second valid/ready handshake. It sits between a command source (bench or controller) and the combinational ALU top. It is the only agent that drives ALU select and operand inputs.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_op_sequencer_if.sv | 50 +++++
 rtl/alu_result_pack.sv | 32 +++
 rtl/alu_op_sequencer.sv | 103 ++++++++++
 tb/tb_alu_op_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and width definitions for the ALU operation sequencer.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int RES_W = 5;

    function automatic logic is_onehot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU select/operand/result bus of the sequencer.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [3:0]       req_a;
    logic [3:0]       req_b;

    logic             alu_s1;
    logic             alu_s0;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_sum;
    logic             alu_carry;
    logic [3:0]       alu_diff;
    logic             alu_dcarry;
    logic             alu_agb;
    logic             alu_alb;
    logic             alu_aeb;
    logic [3:0]       alu_and;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_op;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b,
        input  alu_sum, alu_carry, alu_diff, alu_dcarry,
        input  alu_agb, alu_alb, alu_aeb, alu_and,
        input  rsp_ready,
        output req_ready,
        output alu_s1, alu_s0, alu_a, alu_b,
        output rsp_valid, rsp_op, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b,
        output alu_sum, alu_carry, alu_diff, alu_dcarry,
        output alu_agb, alu_alb, alu_aeb, alu_and,
        output rsp_ready,
        input  req_ready,
        input  alu_s1, alu_s0, alu_a, alu_b,
        input  rsp_valid, rsp_op, rsp_result, rsp_err
    );

endinterface

// File: rtl/alu_result_pack.sv
// Selects and packs the ALU result bus into the response word for the executed opcode.
module alu_result_pack
    import alu_seq_pkg::*;
(
    input  logic [1:0]       i_op,
    input  logic [3:0]       i_sum,
    input  logic             i_carry,
    input  logic [3:0]       i_diff,
    input  logic             i_dcarry,
    input  logic             i_agb,
    input  logic             i_alb,
    input  logic             i_aeb,
    input  logic [3:0]       i_and,
    output logic [RES_W-1:0] o_result,
    output logic             o_err
);

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD: o_result = {i_carry, i_sum};
            OP_SUB: o_result = {i_dcarry, i_diff};
            OP_CMP: begin
                o_result = {2'b00, i_agb, i_alb, i_aeb};
                o_err    = !is_onehot3({i_agb, i_alb, i_aeb});
            end
            default: o_result = {1'b0, i_and};
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Launches one ALU operation per request, waits SETTLE_CYCLES, returns the packed result.
//   state  | meaning
//   IDLE   | ready for a request
//   SETTLE | operands driven, settle counter running
//   RESP   | response held until rsp_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alu_op_sequencer_if.master bus,
    output logic [CNT_W-1:0] o_op_count
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_s1;
    logic             r_s0;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [1:0]       r_rsp_op;
    logic [RES_W-1:0] r_rsp_result;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_op_count;

    logic [RES_W-1:0] w_result;
    logic             w_err;

    alu_result_pack u_pack (
        .i_op     ({r_s1, r_s0}),
        .i_sum    (bus.alu_sum),
        .i_carry  (bus.alu_carry),
        .i_diff   (bus.alu_diff),
        .i_dcarry (bus.alu_dcarry),
        .i_agb    (bus.alu_agb),
        .i_alb    (bus.alu_alb),
        .i_aeb    (bus.alu_aeb),
        .i_and    (bus.alu_and),
        .o_result (w_result),
        .o_err    (w_err)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_s1         <= 1'b0;
            r_s0         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        {r_s1, r_s0} <= bus.req_op;
                        r_a          <= bus.req_a;
                        r_b          <= bus.req_b;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_rsp_op     <= {r_s1, r_s0};
                        r_rsp_result <= w_result;
                        r_rsp_err    <= w_err;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_op_count <= r_op_count + 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) && !i_rst;
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.alu_s1     = r_s1;
    assign bus.alu_s0     = r_s0;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign o_op_count     = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: a 1-cycle/2-bit-counter instance and a 4-cycle/8-bit-counter instance.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel4;
    logic       force_bad;
    logic       tb_req_valid;
    logic [1:0] tb_req_op;
    logic [3:0] tb_req_a;
    logic [3:0] tb_req_b;
    logic       tb_rsp_ready;
    logic [1:0] cnt1;
    logic [7:0] cnt4;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if if1 ();
    alu_op_sequencer_if if4 ();

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1), .o_op_count(cnt1)
    );
    alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
        .i_clk(clk), .i_rst(rst), .bus(if4), .o_op_count(cnt4)
    );

    assign if1.req_valid = tb_req_valid & ~sel4;
    assign if4.req_valid = tb_req_valid & sel4;
    assign if1.rsp_ready = tb_rsp_ready & ~sel4;
    assign if4.rsp_ready = tb_rsp_ready & sel4;
    assign if1.req_op = tb_req_op;
    assign if4.req_op = tb_req_op;
    assign if1.req_a  = tb_req_a;
    assign if4.req_a  = tb_req_a;
    assign if1.req_b  = tb_req_b;
    assign if4.req_b  = tb_req_b;

    // Reference ALU; force_bad makes instance 1 report A>B and A==B together.
    assign {if1.alu_carry, if1.alu_sum}   = {1'b0, if1.alu_a} + {1'b0, if1.alu_b};
    assign {if1.alu_dcarry, if1.alu_diff} = {1'b0, if1.alu_a} + {1'b0, ~if1.alu_b} + 5'd1;
    assign if1.alu_agb = force_bad | (if1.alu_a > if1.alu_b);
    assign if1.alu_alb = ~force_bad & (if1.alu_a < if1.alu_b);
    assign if1.alu_aeb = force_bad | (if1.alu_a == if1.alu_b);
    assign if1.alu_and = if1.alu_a & if1.alu_b;

    assign {if4.alu_carry, if4.alu_sum}   = {1'b0, if4.alu_a} + {1'b0, if4.alu_b};
    assign {if4.alu_dcarry, if4.alu_diff} = {1'b0, if4.alu_a} + {1'b0, ~if4.alu_b} + 5'd1;
    assign if4.alu_agb = (if4.alu_a > if4.alu_b);
    assign if4.alu_alb = (if4.alu_a < if4.alu_b);
    assign if4.alu_aeb = (if4.alu_a == if4.alu_b);
    assign if4.alu_and = if4.alu_a & if4.alu_b;

    logic       m_req_ready, m_rsp_valid, m_rsp_err, m_s1, m_s0;
    logic [1:0] m_rsp_op;
    logic [4:0] m_rsp_result;
    logic [3:0] m_a, m_b;
    logic [7:0] m_cnt;

    assign m_req_ready  = sel4 ? if4.req_ready  : if1.req_ready;
    assign m_rsp_valid  = sel4 ? if4.rsp_valid  : if1.rsp_valid;
    assign m_rsp_err    = sel4 ? if4.rsp_err    : if1.rsp_err;
    assign m_rsp_op     = sel4 ? if4.rsp_op     : if1.rsp_op;
    assign m_rsp_result = sel4 ? if4.rsp_result : if1.rsp_result;
    assign m_s1         = sel4 ? if4.alu_s1     : if1.alu_s1;
    assign m_s0         = sel4 ? if4.alu_s0     : if1.alu_s0;
    assign m_a          = sel4 ? if4.alu_a      : if1.alu_a;
    assign m_b          = sel4 ? if4.alu_b      : if1.alu_b;
    assign m_cnt        = sel4 ? cnt4 : {6'b0, cnt1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the selected instance and complete its response.
    task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] exp_res, input logic exp_err, input int hold,
                         input int exp_lat, input logic [7:0] exp_cnt);
        int lat;
        chk("req_ready_idle", m_req_ready, 1);
        tb_req_valid = 1'b1;
        tb_req_op    = op;
        tb_req_a     = a;
        tb_req_b     = b;
        tick();
        tb_req_valid = 1'b0;
        chk("alu_sel", {m_s1, m_s0}, op);
        chk("alu_a", m_a, a);
        chk("alu_b", m_b, b);
        chk("req_ready_busy", m_req_ready, 0);
        chk("rsp_valid_settle", m_rsp_valid, 0);
        lat = 0;
        while (!m_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_op", m_rsp_op, op);
        chk("rsp_result", m_rsp_result, exp_res);
        chk("rsp_err", m_rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", m_rsp_valid, 1);
            chk("hold_result", m_rsp_result, exp_res);
            chk("hold_req_ready", m_req_ready, 0);
        end
        tb_rsp_ready = 1'b1;
        tick();
        tb_rsp_ready = 1'b0;
        chk("rsp_valid_drop", m_rsp_valid, 0);
        chk("op_count", m_cnt, exp_cnt);
        chk("req_ready_after", m_req_ready, 1);
        chk("alu_a_hold", m_a, a);
        chk("alu_sel_hold", {m_s1, m_s0}, op);
    endtask

    initial begin
        rst          = 1'b1;
        sel4         = 1'b0;
        force_bad    = 1'b0;
        tb_req_valid = 1'b0;
        tb_req_op    = 2'b00;
        tb_req_a     = 4'h0;
        tb_req_b     = 4'h0;
        tb_rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", if1.req_ready, 0);
        chk("rst_rsp_valid", if1.rsp_valid, 0);
        rst = 1'b0;
        #1;
        chk("init_req_ready1", if1.req_ready, 1);
        chk("init_req_ready4", if4.req_ready, 1);
        chk("init_cnt1", cnt1, 0);
        chk("init_alu1", {if1.alu_s1, if1.alu_s0, if1.alu_a, if1.alu_b}, 0);
        chk("init_rsp1", {if1.rsp_op, if1.rsp_result, if1.rsp_err}, 0);

        // SETTLE_CYCLES=1, CNT_W=2: counts 1,2,3,0,1,2
        do_op(2'b00, 4'b0111, 4'b0101, 5'b01100, 1'b0, 0, 1, 8'd1);
        do_op(2'b01, 4'b0101, 4'b0011, 5'b10010, 1'b0, 0, 1, 8'd2);
        do_op(2'b10, 4'b1001, 4'b0110, 5'b00100, 1'b0, 0, 1, 8'd3);
        do_op(2'b10, 4'b1010, 4'b1010, 5'b00001, 1'b0, 0, 1, 8'd0);
        force_bad = 1'b1;
        do_op(2'b10, 4'b0110, 4'b0110, 5'b00101, 1'b1, 0, 1, 8'd1);
        force_bad = 1'b0;
        do_op(2'b11, 4'b1100, 4'b1010, 5'b01000, 1'b0, 3, 1, 8'd2);

        // SETTLE_CYCLES=4 instance
        sel4 = 1'b1;
        #1;
        do_op(2'b00, 4'b0011, 4'b0100, 5'b00111, 1'b0, 0, 4, 8'd1);
        do_op(2'b01, 4'b0010, 4'b0101, 5'b01101, 1'b0, 1, 4, 8'd2);

        // Reset two cycles into SETTLE drops the operation
        tb_req_valid = 1'b1;
        tb_req_op    = 2'b11;
        tb_req_a     = 4'hF;
        tb_req_b     = 4'hF;
        tick();
        tb_req_valid = 1'b0;
        chk("mid_alu_a", m_a, 4'hF);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_req_ready_rst", m_req_ready, 0);
        tick();
        chk("mid_rsp_valid", m_rsp_valid, 0);
        chk("mid_alu_lines", {m_s1, m_s0, m_a, m_b}, 0);
        chk("mid_rsp_regs", {m_rsp_op, m_rsp_result, m_rsp_err}, 0);
        chk("mid_op_count", m_cnt, 0);
        rst = 1'b0;
        #1;
        chk("mid_req_ready_rel", m_req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_rsp", m_rsp_valid, 0);
        end
        do_op(2'b10, 4'b0001, 4'b0010, 5'b00010, 1'b0, 0, 4, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
